// File: rtl/sid_sequencer.sv
// Central pipeline sequencer shared by NUM_SIDS SID instances: voice/filter cycle
// counters, ~1 kHz tick, OSC3/ENV3 readback, EXT IN steering and audio word assembly.
module sid_sequencer #(
    parameter int NUM_SIDS  = 2,
    parameter int TICK_BITS = 10,
    localparam int VLAST    = 6 + 6 * NUM_SIDS,
    localparam int FLAST    = 5 * NUM_SIDS + 4,
    localparam int CW       = $clog2(VLAST + 1),
    localparam int FW       = $clog2(FLAST + 1),
    localparam int AW       = 24 * NUM_SIDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  phi2,
    output logic [CW-1:0]         voice_cycle,
    output logic [FW-1:0]         filter_cycle,
    output logic                  tick_ms,
    output logic                  overrun,
    input  logic [11:0]           wav,
    input  logic [7:0]            env,
    output logic [8*NUM_SIDS-1:0] osc3,
    output logic [8*NUM_SIDS-1:0] env3,
    input  logic [AW-1:0]         audio_i,
    output logic [21:0]           ext_voice,
    input  logic [19:0]           filter_o,
    output logic [AW-1:0]         audio_o,
    output logic                  audio_valid
);

    localparam logic [CW-1:0] VLAST_C = CW'(VLAST);
    localparam logic [FW-1:0] FLAST_C = FW'(FLAST);

    logic                       phi2_prev;
    logic                       phi2_fall;
    logic                       restart_abort;
    logic                       stall;
    logic [CW-1:0]              voice_cnt;
    logic [CW-1:0]              voice_next;
    logic [FW-1:0]              filter_cnt;
    logic [FW-1:0]              filter_next;
    logic [TICK_BITS-1:0]       prescale;
    logic [AW-1:0]              ext_sr;
    logic [NUM_SIDS-1:0]        cap_hit;
    logic [NUM_SIDS-1:0]        slot_hit;
    logic [NUM_SIDS-1:0]        shift_hit;
    logic [NUM_SIDS-1:0][23:0]  slot;
    logic [NUM_SIDS-1:0][23:0]  slot_next;
    logic [AW-1:0]              audio_next;
    logic                       wav_unused;

    assign wav_unused    = ^wav[3:0];
    assign phi2_fall     = phi2_prev & ~phi2;
    assign restart_abort = phi2_fall && (voice_cnt != '0);

    assign voice_cycle  = stall ? '0 : voice_cnt;
    assign filter_cycle = filter_cnt;
    assign tick_ms      = &prescale;
    assign ext_voice    = ext_sr[AW-1 -: 22];

    // Filter-cycle decodes: voice stall windows, per-SID staging slots and EXT IN shifts.
    always_comb begin
        stall     = 1'b0;
        slot_hit  = '0;
        shift_hit = '0;
        for (int k = 0; k < NUM_SIDS; k++) begin
            if (filter_cnt == FW'(5 * k + 4) || filter_cnt == FW'(5 * k + 5)) begin
                stall = 1'b1;
            end
            slot_hit[k] = (filter_cnt == FW'(5 * k + 9));
            if (k < NUM_SIDS - 1) begin
                shift_hit[k] = (filter_cnt == FW'(5 * k + 6));
            end
        end
    end

    always_comb begin
        cap_hit = '0;
        for (int k = 0; k < NUM_SIDS; k++) begin
            cap_hit[k] = (voice_cycle == CW'(8 + 3 * k));
        end
    end

    // A phi2 fall always restarts the voice pipeline; if it lands mid-frame the
    // in-flight filter frame is abandoned so a half-built audio word never escapes.
    always_comb begin
        voice_next = voice_cnt;
        if (phi2_fall) begin
            voice_next = CW'(1);
        end else if (voice_cnt == VLAST_C) begin
            voice_next = '0;
        end else if (voice_cnt != '0 && !stall) begin
            voice_next = voice_cnt + 1'b1;
        end

        filter_next = filter_cnt;
        if (restart_abort) begin
            filter_next = '0;
        end else if (filter_cnt == FLAST_C) begin
            filter_next = '0;
        end else if (filter_cnt != '0) begin
            filter_next = filter_cnt + 1'b1;
        end else if (voice_cycle == CW'(6)) begin
            filter_next = FW'(1);
        end
    end

    // The final slot is merged combinationally so audio_o sees it in the same clock.
    always_comb begin
        slot_next = slot;
        for (int k = 0; k < NUM_SIDS; k++) begin
            if (slot_hit[k]) begin
                slot_next[k] = {filter_o, 4'b0000};
            end
        end
        audio_next = '0;
        for (int k = 0; k < NUM_SIDS; k++) begin
            audio_next[24 * (NUM_SIDS - 1 - k) +: 24] = slot_next[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phi2_prev  <= 1'b0;
            voice_cnt  <= '0;
            filter_cnt <= '0;
            prescale   <= '0;
            overrun    <= 1'b0;
        end else begin
            phi2_prev  <= phi2;
            voice_cnt  <= voice_next;
            filter_cnt <= filter_next;
            overrun    <= restart_abort;
            if (voice_cycle == CW'(1)) begin
                prescale <= prescale + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            osc3 <= '0;
            env3 <= '0;
        end else begin
            for (int k = 0; k < NUM_SIDS; k++) begin
                if (cap_hit[k]) begin
                    osc3[8 * k +: 8] <= wav[11:4];
                    env3[8 * k +: 8] <= env;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_sr      <= '0;
            slot        <= '0;
            audio_o     <= '0;
            audio_valid <= 1'b0;
        end else begin
            if (filter_cnt == FW'(1)) begin
                ext_sr <= audio_i;
            end else if (|shift_hit) begin
                ext_sr <= ext_sr << 24;
            end

            audio_valid <= 1'b0;
            if (!restart_abort) begin
                slot <= slot_next;
                if (slot_hit[NUM_SIDS-1]) begin
                    audio_o     <= audio_next;
                    audio_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sid_sequencer.sv
// Scoreboard bench for sid_sequencer: 1-, 2- and 4-SID instances run in lockstep
// from shared phi2/wav/env/filter_o stimulus and are compared against a timeline model.
module tb_sid_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        phi2;
    logic [11:0] wav;
    logic [7:0]  env;
    logic [19:0] filter_o;

    logic [23:0] audio_i1;
    logic [47:0] audio_i2;
    logic [95:0] audio_i4;

    logic [3:0]  voice1, filter1;
    logic        tick1, ovr1, valid1;
    logic [7:0]  osc31, env31;
    logic [21:0] ext1;
    logic [23:0] aud1;

    logic [4:0]  voice2;
    logic [3:0]  filter2;
    logic        tick2, ovr2, valid2;
    logic [15:0] osc32, env32;
    logic [21:0] ext2;
    logic [47:0] aud2;

    logic [4:0]  voice4, filter4;
    logic        tick4, ovr4, valid4;
    logic [31:0] osc34, env34;
    logic [21:0] ext4;
    logic [95:0] aud4;

    int checks = 0;
    int errors = 0;
    int pcnt   = 0;

    logic [95:0] q1[$];
    logic [95:0] q2[$];
    logic [95:0] q4[$];
    logic [95:0] last1, last2, last4;

    sid_sequencer #(.NUM_SIDS(1), .TICK_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .phi2(phi2), .voice_cycle(voice1), .filter_cycle(filter1),
        .tick_ms(tick1), .overrun(ovr1), .wav(wav), .env(env), .osc3(osc31), .env3(env31),
        .audio_i(audio_i1), .ext_voice(ext1), .filter_o(filter_o), .audio_o(aud1),
        .audio_valid(valid1)
    );

    sid_sequencer #(.NUM_SIDS(2), .TICK_BITS(10)) dut2 (
        .clk(clk), .rst(rst), .phi2(phi2), .voice_cycle(voice2), .filter_cycle(filter2),
        .tick_ms(tick2), .overrun(ovr2), .wav(wav), .env(env), .osc3(osc32), .env3(env32),
        .audio_i(audio_i2), .ext_voice(ext2), .filter_o(filter_o), .audio_o(aud2),
        .audio_valid(valid2)
    );

    sid_sequencer #(.NUM_SIDS(4), .TICK_BITS(2)) dut4 (
        .clk(clk), .rst(rst), .phi2(phi2), .voice_cycle(voice4), .filter_cycle(filter4),
        .tick_ms(tick4), .overrun(ovr4), .wav(wav), .env(env), .osc3(osc34), .env3(env34),
        .audio_i(audio_i4), .ext_voice(ext4), .filter_o(filter_o), .audio_o(aud4),
        .audio_valid(valid4)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference timeline, counted from the clk where voice_cycle first reads 1.
    function automatic int expFilter(input int n, input int t);
        if (t >= 6 && t <= 5 + 5 * n + 4) return t - 5;
        return 0;
    endfunction

    function automatic bit expStall(input int n, input int t);
        int f = expFilter(n, t);
        for (int k = 0; k < n; k++) begin
            if (f == 5 * k + 4 || f == 5 * k + 5) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int expVoice(input int n, input int t);
        int cnt = 1;
        int vlast = 6 + 6 * n;
        for (int i = 0; i < t; i++) begin
            if (cnt == vlast) cnt = 0;
            else if (cnt != 0 && !expStall(n, i)) cnt++;
        end
        return expStall(n, t) ? 0 : cnt;
    endfunction

    function automatic int capTime(input int n, input int k);
        for (int t = 0; t < 60; t++) begin
            if (expVoice(n, t) == 8 + 3 * k) return t;
        end
        return -1;
    endfunction

    function automatic logic [19:0] fval(input int seed, input int f);
        logic [31:0] h;
        if (seed == 0 && f == 9)  return 20'h12345;
        if (seed == 0 && f == 14) return 20'hFEDCB;
        h = (f * 32'h9E3779B1) ^ seed;
        return h[19:0];
    endfunction

    function automatic logic [95:0] expAudio(input int n, input int seed);
        logic [95:0] e = '0;
        for (int k = 0; k < n; k++) begin
            e[24 * (n - 1 - k) +: 24] = {fval(seed, 5 * k + 9), 4'b0000};
        end
        return e;
    endfunction

    function automatic logic [95:0] expCap(input int n, input bit held, input bit is_env);
        logic [95:0] e = '0;
        logic [7:0]  b;
        for (int k = 0; k < n; k++) begin
            b = 8'(capTime(n, k));
            if (held) b = is_env ? 8'h5A : 8'hAB;
            else if (is_env) b = ~b;
            e[8 * k +: 8] = b;
        end
        return e;
    endfunction

    function automatic logic [21:0] extWord(input logic [95:0] a, input int n, input int k);
        logic [95:0] s = a >> (24 * (n - 1 - k));
        return s[23:2];
    endfunction

    function automatic logic tickExp(input int bits);
        int m = (1 << bits) - 1;
        return (pcnt & m) == m;
    endfunction

    // Every audio_valid must be matched by a word queued when its frame was launched.
    always @(negedge clk) begin
        if (valid1 === 1'b1) begin
            if (q1.size() == 0) checkOutput("valid1_spurious", 96'(valid1), 96'd0);
            else checkOutput("audio1", 96'(aud1), q1.pop_front());
        end
        if (valid2 === 1'b1) begin
            if (q2.size() == 0) checkOutput("valid2_spurious", 96'(valid2), 96'd0);
            else checkOutput("audio2", 96'(aud2), q2.pop_front());
        end
        if (valid4 === 1'b1) begin
            if (q4.size() == 0) checkOutput("valid4_spurious", 96'(valid4), 96'd0);
            else checkOutput("audio4", aud4, q4.pop_front());
        end
    end

    task automatic applyStimulus();
        @(negedge clk);
        phi2 = 1'b1;
        @(negedge clk);
        phi2 = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_ctl1"}, 96'({voice1, filter1, tick1, ovr1, valid1}), 96'd0);
        checkOutput({tag, "_rb1"},  96'({osc31, env31}), 96'd0);
        checkOutput({tag, "_dat1"}, 96'({ext1, aud1}), 96'd0);
        checkOutput({tag, "_ctl2"}, 96'({voice2, filter2, tick2, ovr2, valid2}), 96'd0);
        checkOutput({tag, "_rb2"},  96'({osc32, env32}), 96'd0);
        checkOutput({tag, "_dat2"}, 96'({ext2, aud2}), 96'd0);
        checkOutput({tag, "_ctl4"}, 96'({voice4, filter4, tick4, ovr4, valid4}), 96'd0);
        checkOutput({tag, "_rb4"},  96'({osc34, env34}), 96'd0);
        checkOutput({tag, "_ext4"}, 96'(ext4), 96'd0);
        checkOutput({tag, "_aud4"}, aud4, 96'd0);
    endtask

    task automatic runFrame(input int scen, input int len, input bit complete,
                            input bit ovr_first, input int rst_at);
        int          seed = (scen == 0) ? 0 : 32'h5100 + scen;
        logic [7:0]  tb8;
        if (scen == 0) audio_i2 = 48'hAAAAAA_555555;
        else audio_i2 = {16'($urandom), $urandom};
        audio_i1 = 24'($urandom);
        audio_i4 = {$urandom, $urandom, $urandom};
        if (complete) begin
            last1 = expAudio(1, seed);
            last2 = expAudio(2, seed);
            last4 = expAudio(4, seed);
            q1.push_back(last1);
            q2.push_back(last2);
            q4.push_back(last4);
        end
        applyStimulus();
        for (int t = 0; t < len; t++) begin
            @(negedge clk);
            if (t == 1) pcnt++;
            checkOutput($sformatf("voice1_t%0d", t),  96'(voice1),  96'(expVoice(1, t)));
            checkOutput($sformatf("voice2_t%0d", t),  96'(voice2),  96'(expVoice(2, t)));
            checkOutput($sformatf("voice4_t%0d", t),  96'(voice4),  96'(expVoice(4, t)));
            checkOutput($sformatf("filter1_t%0d", t), 96'(filter1), 96'(expFilter(1, t)));
            checkOutput($sformatf("filter2_t%0d", t), 96'(filter2), 96'(expFilter(2, t)));
            checkOutput($sformatf("filter4_t%0d", t), 96'(filter4), 96'(expFilter(4, t)));
            checkOutput($sformatf("ovr_t%0d", t), 96'({ovr1, ovr2, ovr4}),
                        (ovr_first && t == 0) ? 96'd7 : 96'd0);
            checkOutput($sformatf("tick_t%0d", t), 96'({tick1, tick2, tick4}),
                        96'({tickExp(2), tickExp(10), tickExp(2)}));
            if (t >= 7 && (t - 7) % 5 == 0) begin
                if ((t - 7) / 5 < 1) checkOutput("ext1", 96'(ext1), 96'(extWord(96'(audio_i1), 1, 0)));
                if ((t - 7) / 5 < 2) checkOutput("ext2", 96'(ext2), 96'(extWord(96'(audio_i2), 2, (t - 7) / 5)));
                if ((t - 7) / 5 < 4) checkOutput("ext4", 96'(ext4), 96'(extWord(audio_i4, 4, (t - 7) / 5)));
            end
            if (scen == 0 && t == 8) begin
                checkOutput("osc3_sid0_only", 96'(osc32), 96'h00AB);
                checkOutput("env3_sid0_only", 96'(env32), 96'h005A);
            end
            if (scen == 0 && t == 13) begin
                checkOutput("osc3_both", 96'(osc32), 96'hABAB);
                checkOutput("env3_both", 96'(env32), 96'h5A5A);
            end
            if (complete && t == len - 1) begin
                checkOutput("rb_osc1", 96'(osc31), expCap(1, scen == 0, 1'b0));
                checkOutput("rb_env1", 96'(env31), expCap(1, scen == 0, 1'b1));
                checkOutput("rb_osc4", 96'(osc34), expCap(4, scen == 0, 1'b0));
                checkOutput("rb_env4", 96'(env34), expCap(4, scen == 0, 1'b1));
                checkOutput("hold1", 96'(aud1), last1);
                checkOutput("hold2", 96'(aud2), last2);
                checkOutput("hold4", aud4, last4);
            end
            tb8      = 8'(t);
            filter_o = fval(seed, t - 5);
            wav      = (scen == 0) ? 12'hABC : {tb8, 4'h3};
            env      = (scen == 0) ? 8'h5A : ~tb8;
            if (t == rst_at) rst = 1'b1;
        end
    endtask

    initial begin
        rst      = 1'b1;
        phi2     = 1'b0;
        wav      = '0;
        env      = '0;
        filter_o = '0;
        audio_i1 = '0;
        audio_i2 = '0;
        audio_i4 = '0;
        repeat (3) @(negedge clk);
        checkIdle("reset");
        rst = 1'b0;

        runFrame(0, 40, 1'b1, 1'b0, -1);
        runFrame(1, 40, 1'b1, 1'b0, -1);
        // Next fall lands while voice_cycle reads 10: overrun restart, frame dropped.
        runFrame(2, 10, 1'b0, 1'b0, -1);
        runFrame(3, 40, 1'b1, 1'b1, -1);
        // Reset asserted while filter_cycle reads 7.
        runFrame(4, 13, 1'b0, 1'b0, 12);
        @(negedge clk);
        checkIdle("rst_mid");
        rst  = 1'b0;
        pcnt = 0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("idle_counters", 96'({voice1, filter1, voice2, filter2, voice4, filter4}), 96'd0);
        end
        runFrame(5, 40, 1'b1, 1'b0, -1);
        runFrame(6, 40, 1'b1, 1'b0, -1);
        runFrame(7, 40, 1'b1, 1'b0, -1);

        repeat (4) @(negedge clk);
        checkOutput("q1_left", 96'(q1.size()), 96'd0);
        checkOutput("q2_left", 96'(q2.size()), 96'd0);
        checkOutput("q4_left", 96'(q4.size()), 96'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
